mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the single physical-memory port between the instruction-cache miss path and the data-cache miss/writeback path of the 5-stage RV32I pipeline. It grants one requester at a time, holds the granted address and write data in registers for the whole transaction, and routes the memory response back to the winner. Data-side requests have priority, with a bounded-streak rule that guarantees instruction fetch cannot starve.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 256, cache line width in bits
- D_STREAK_MAX, 4, max consecutive D grants while I waits (>=1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- i_read  in  1  I-cache line read request, held until i_resp
- i_addr  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion strobe to I-cache
- d_read  in  1  D-cache line read request, held until d_resp
- d_write  in  1  D-cache line writeback request, held until d_resp
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  writeback line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion strobe to D-cache
- pmem_read  out  1  memory read command, registered
- pmem_write  out  1  memory write command, registered
- pmem_addr  out  ADDR_W  registered address
- pmem_wdata  out  LINE_W  registered write data
- pmem_rdata  in  LINE_W  memory read data, valid with pmem_resp
- pmem_resp  in  1  memory completion strobe
- grant_d  out  1  1 while serving D side (debug/perf)
- busy  out  1  1 in any non-IDLE state

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- IDLE decision (evaluated every IDLE cycle): D pending = d_read|d_write.
  - D pending, and not (i_read and streak==D_STREAK_MAX) -> SERVE_D.
  - else i_read -> SERVE_I.
  - else stay IDLE.
- On grant edge: latch addr (and d_wdata for D) into pmem_addr/pmem_wdata; set pmem_read or pmem_write. d_read and d_write both high: treat as write.
- SERVE_x: hold pmem_* constant; ignore request-input changes. On pmem_resp: drop pmem_read/pmem_write at that edge, return to IDLE.
- i_resp = pmem_resp & (state==SERVE_I); d_resp = pmem_resp & (state==SERVE_D); combinational.
- i_rdata and d_rdata both driven from pmem_rdata (qualified only by resp).
- Streak counter (width clog2(D_STREAK_MAX+1)): +1 on each D grant made while i_read high, saturating at D_STREAK_MAX; cleared on every I grant; unchanged by D grants with i_read low.
- pmem_resp in IDLE: ignored, no resp strobes.

## Timing
- Reset (rst_n low at edge): state=IDLE, streak=0, pmem_read=0, pmem_write=0, pmem_addr=0, pmem_wdata=0; grant_d=0, busy=0, i_resp=d_resp=0. Reset mid-transaction abandons it; commands low the cycle after the reset edge.
- Request high in IDLE during cycle t -> pmem command high from cycle t+1.
- pmem_resp in cycle k -> x_resp in cycle k (same cycle), command low and IDLE from k+1.
- Earliest next grant decision at k+1; next command at k+2. One IDLE bubble between back-to-back transactions, always.
- Requesters must drop their request in the cycle after resp; arbiter samples requests only in IDLE.
- Minimum transaction: 2 cycles command-to-command when memory responds in the first command cycle.

## Test plan
- Lone I read: i_read=1, i_addr=0x0000_0040; memory responds 3 cycles after command -> pmem_read=1, pmem_addr=0x40 from t+1; i_resp=1 with i_rdata=pmem_rdata exactly in resp cycle; d_resp never high.
- Simultaneous I/D: i_read and d_read both high in IDLE -> D served first (grant_d=1), then I granted at first IDLE after d_resp; streak=1 then 0.
- Starvation bound, D_STREAK_MAX=4: d_read held continuously (new address each time), i_read held -> D granted 4 times, 5th grant to I; pattern repeats.
- Writeback: d_write=1, d_addr=0x8000_0100, d_wdata=all 0xA5 -> pmem_write=1 and pmem_wdata stable across 10-cycle memory latency even if d_wdata changes mid-transaction; pmem_read stays 0.
- Reset mid-operation: rst_n low during SERVE_D -> next cycle pmem_read=pmem_write=0, busy=0, streak=0; stray pmem_resp afterward produces no d_resp.
- Spurious/stability: pmem_resp pulsed in IDLE -> no resp strobe; i_addr toggled during SERVE_I -> pmem_addr unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter for the single physical-memory port shared by the I-cache miss path and the
// D-cache miss/writeback path; D wins by default, a bounded D streak protects fetch.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned LINE_W       = 256,
    parameter int unsigned D_STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              grant_d,
    output logic              busy
);
    localparam int unsigned            STREAK_W   = $clog2(D_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0]    STREAK_LIM = STREAK_W'(D_STREAK_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE_I,
        ST_SERVE_D
    } state_t;

    state_t              r_state;
    logic [STREAK_W-1:0] r_streak;
    logic                r_pmem_read;
    logic                r_pmem_write;
    logic [ADDR_W-1:0]   r_pmem_addr;
    logic [LINE_W-1:0]   r_pmem_wdata;

    logic w_d_pend;
    logic w_i_starved;
    logic w_pick_d;

    // D wins unless I is waiting and the D streak has reached its limit
    assign w_d_pend    = d_read | d_write;
    assign w_i_starved = i_read && (r_streak == STREAK_LIM);
    assign w_pick_d    = w_d_pend && !w_i_starved;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_streak     <= '0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_pmem_addr  <= '0;
            r_pmem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_d) begin
                        r_state      <= ST_SERVE_D;
                        r_pmem_addr  <= d_addr;
                        r_pmem_wdata <= d_wdata;
                        r_pmem_write <= d_write;
                        r_pmem_read  <= !d_write;
                        if (i_read && (r_streak != STREAK_LIM)) begin
                            r_streak <= r_streak + STREAK_W'(1);
                        end
                    end else if (i_read) begin
                        r_state     <= ST_SERVE_I;
                        r_pmem_addr <= i_addr;
                        r_pmem_read <= 1'b1;
                        r_streak    <= '0;
                    end
                end
                ST_SERVE_I, ST_SERVE_D: begin
                    if (pmem_resp) begin
                        r_state      <= ST_IDLE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pmem_read  = r_pmem_read;
    assign pmem_write = r_pmem_write;
    assign pmem_addr  = r_pmem_addr;
    assign pmem_wdata = r_pmem_wdata;

    // Response routing is same-cycle so the requester sees data with the memory strobe
    assign i_resp  = pmem_resp && (r_state == ST_SERVE_I);
    assign d_resp  = pmem_resp && (r_state == ST_SERVE_D);
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;
    assign grant_d = (r_state == ST_SERVE_D);
    assign busy    = (r_state != ST_IDLE);

endmodule
